// File: rtl/etapa_busqueda_if.sv
`default_nettype none
// ============================================================================
// Module   : etapa_busqueda_if
// Brief    : Instruction-memory read port between the fetch stage and ROM.
// Revision : 1.0
// ============================================================================
interface etapa_busqueda_if #(
  parameter int ANCHO_DIR   = 10,
  parameter int ANCHO_INSTR = 32
);
  logic [ANCHO_DIR-1:0]   direccion;
  logic [ANCHO_INSTR-1:0] instruccion;

  modport master (output direccion, input instruccion);
  modport slave  (input direccion, output instruccion);
endinterface
`default_nettype wire

// File: rtl/etapa_busqueda.sv
`default_nettype none
// ============================================================================
// Module   : etapa_busqueda
// Brief    : Instruction-fetch stage with IF/ID pipeline register.
// Revision : 1.0
// ============================================================================
module etapa_busqueda #(
  parameter int                     ANCHO_DIR   = 10,
  parameter int                     ANCHO_INSTR = 32,
  parameter logic [ANCHO_DIR-1:0]   PC_RESET    = '0,
  parameter logic [ANCHO_INSTR-1:0] INSTR_HLT   = '0
) (
  input  wire                    clk,
  input  wire                    rst_n,
  etapa_busqueda_if.master       imem,
  input  wire                    stall,
  input  wire                    salto_tomado,
  input  wire  [ANCHO_DIR-1:0]   dir_salto,
  output logic [ANCHO_INSTR-1:0] ifid_instruccion,
  output logic [ANCHO_DIR-1:0]   ifid_pc_mas1,
  output logic                   ifid_valido,
  output logic                   detenido
);

  localparam logic [ANCHO_DIR-1:0] c_uno = {{(ANCHO_DIR-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ARRANQUE = 2'd0,
    CORRE    = 2'd1,
    ALTO     = 2'd2
  } estado_t;

  estado_t                r_estado, w_estado_sig;
  logic [ANCHO_DIR-1:0]   r_pc, w_pc_sig, w_pc_mas1;
  logic [ANCHO_INSTR-1:0] r_instr, w_instr_sig;
  logic [ANCHO_DIR-1:0]   r_pc1, w_pc1_sig;
  logic                   r_valido, w_valido_sig;

  assign w_pc_mas1        = r_pc + c_uno;
  assign imem.direccion   = r_pc;
  assign ifid_instruccion = r_instr;
  assign ifid_pc_mas1     = r_pc1;
  assign ifid_valido      = r_valido;
  assign detenido         = (r_estado == ALTO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= ARRANQUE;
      r_pc     <= PC_RESET;
      r_instr  <= '0;
      r_pc1    <= '0;
      r_valido <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      r_pc     <= w_pc_sig;
      r_instr  <= w_instr_sig;
      r_pc1    <= w_pc1_sig;
      r_valido <= w_valido_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    w_pc_sig     = r_pc;
    w_instr_sig  = r_instr;
    w_pc1_sig    = r_pc1;
    w_valido_sig = r_valido;
    case (r_estado)
      // The memory word is not trustworthy until one full negedge read of rom[pc].
      ARRANQUE: begin
        w_valido_sig = 1'b0;
        if (salto_tomado) w_pc_sig = dir_salto;
        else              w_estado_sig = CORRE;
      end
      CORRE: begin
        if (salto_tomado) begin
          w_pc_sig     = dir_salto;
          w_valido_sig = 1'b0;
        end else if (!stall) begin
          w_instr_sig  = imem.instruccion;
          w_pc1_sig    = w_pc_mas1;
          w_valido_sig = 1'b1;
          w_pc_sig     = w_pc_mas1;
          if (imem.instruccion == INSTR_HLT) w_estado_sig = ALTO;
        end
      end
      ALTO: begin
        w_valido_sig = 1'b0;
        if (salto_tomado) begin
          w_pc_sig     = dir_salto;
          w_estado_sig = CORRE;
        end
      end
      default: w_estado_sig = ARRANQUE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_etapa_busqueda.sv
`default_nettype none
// ============================================================================
// Module   : tb_etapa_busqueda
// Brief    : Vector table, corner sequences and randomized model check.
// Revision : 1.0
// ============================================================================
module tb_etapa_busqueda;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        salto_tomado = 1'b0;
  logic [9:0]  dir_salto = '0;
  logic [31:0] ifid_instruccion;
  logic [9:0]  ifid_pc_mas1;
  logic        ifid_valido;
  logic        detenido;
  logic [31:0] rom [1024];
  logic [31:0] mem_q;

  int n_vec = 0;
  int n_err = 0;

  etapa_busqueda_if #(.ANCHO_DIR(10), .ANCHO_INSTR(32)) bus ();

  etapa_busqueda #(
    .ANCHO_DIR(10), .ANCHO_INSTR(32), .PC_RESET(10'd0), .INSTR_HLT(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus), .stall(stall),
    .salto_tomado(salto_tomado), .dir_salto(dir_salto),
    .ifid_instruccion(ifid_instruccion), .ifid_pc_mas1(ifid_pc_mas1),
    .ifid_valido(ifid_valido), .detenido(detenido)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: address sampled on negedge, word held until next negedge.
  always @(negedge clk) mem_q <= rom[bus.direccion];
  assign bus.instruccion = mem_q;

  typedef struct {
    logic        st;
    logic        sl;
    logic [9:0]  dst;
    logic        v;
    logic [31:0] ins;
    logic [9:0]  p1;
    logic        det;
    logic [9:0]  dir;
  } vec_t;

  vec_t tabla [16];

  // Reference model state
  int          m_pc;
  int          m_p1;
  bit          m_arrancado;
  bit          m_alto;
  bit          m_v;
  logic [31:0] m_ins;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nombre, logic v, logic [31:0] ins, logic [9:0] p1,
                       logic det, logic [9:0] dir, bit datos);
    bit ok;
    n_vec++;
    ok = (ifid_valido === v) && (detenido === det) && (bus.direccion === dir);
    if (datos) ok = ok && (ifid_instruccion === ins) && (ifid_pc_mas1 === p1);
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got v=%0b ins=%h p1=%h det=%0b dir=%h, expected v=%0b ins=%h p1=%h det=%0b dir=%h",
               nombre, ifid_valido, ifid_instruccion, ifid_pc_mas1, detenido, bus.direccion,
               v, ins, p1, det, dir);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    salto_tomado = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic rom_base();
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;
    rom[0]     = 32'h00210820;
    rom[1]     = 32'hAC010001;
    rom[2]     = 32'h00212020;
    rom[10'h3FE] = 32'h11111111;
    rom[10'h3FF] = 32'h22222222;
  endtask

  task automatic modelo_reset();
    m_pc = 0; m_p1 = 0; m_arrancado = 0; m_alto = 0; m_v = 0; m_ins = 32'h0;
  endtask

  task automatic modelo_paso(bit st, bit sl, int dst);
    if (!m_arrancado) begin
      m_v = 0;
      if (sl) m_pc = dst;
      else    m_arrancado = 1;
    end else if (sl) begin
      m_v = 0; m_pc = dst; m_alto = 0;
    end else if (m_alto) begin
      m_v = 0;
    end else if (!st) begin
      m_ins  = rom[m_pc];
      m_p1   = (m_pc + 1) % 1024;
      m_v    = 1;
      m_alto = (m_ins == 32'h0);
      m_pc   = m_p1;
    end
  endtask

  initial begin
    rom_base();
    //            st sl dst     | v  ins            p1      det dir
    tabla[0]  = '{0, 0, 10'h0,   0, 32'h0,        10'h0,   0, 10'h0};
    tabla[1]  = '{0, 0, 10'h0,   1, 32'h00210820, 10'h1,   0, 10'h1};
    tabla[2]  = '{1, 0, 10'h0,   1, 32'h00210820, 10'h1,   0, 10'h1};
    tabla[3]  = '{1, 0, 10'h0,   1, 32'h00210820, 10'h1,   0, 10'h1};
    tabla[4]  = '{0, 0, 10'h0,   1, 32'hAC010001, 10'h2,   0, 10'h2};
    tabla[5]  = '{0, 0, 10'h0,   1, 32'h00212020, 10'h3,   0, 10'h3};
    tabla[6]  = '{0, 0, 10'h0,   1, 32'h00000000, 10'h4,   1, 10'h4};
    tabla[7]  = '{0, 0, 10'h0,   0, 32'h0,        10'h0,   1, 10'h4};
    tabla[8]  = '{1, 0, 10'h0,   0, 32'h0,        10'h0,   1, 10'h4};
    tabla[9]  = '{0, 1, 10'h1,   0, 32'h0,        10'h0,   0, 10'h1};
    tabla[10] = '{0, 0, 10'h0,   1, 32'hAC010001, 10'h2,   0, 10'h2};
    tabla[11] = '{1, 1, 10'h3FE, 0, 32'h0,        10'h0,   0, 10'h3FE};
    tabla[12] = '{0, 0, 10'h0,   1, 32'h11111111, 10'h3FF, 0, 10'h3FF};
    tabla[13] = '{0, 0, 10'h0,   1, 32'h22222222, 10'h0,   0, 10'h0};
    tabla[14] = '{0, 0, 10'h0,   1, 32'h00210820, 10'h1,   0, 10'h1};
    tabla[15] = '{1, 0, 10'h0,   1, 32'h00210820, 10'h1,   0, 10'h1};

    do_reset();
    check("reset_state", 0, 32'h0, 10'h0, 0, 10'h0, 1);
    for (int i = 0; i < 16; i++) begin
      stall = tabla[i].st; salto_tomado = tabla[i].sl; dir_salto = tabla[i].dst;
      tick();
      check($sformatf("tabla[%0d]", i), tabla[i].v, tabla[i].ins, tabla[i].p1,
            tabla[i].det, tabla[i].dir, tabla[i].v);
    end
    stall = 0; salto_tomado = 0;

    // Asynchronous reset between edges, with control inputs asserted meanwhile
    tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", 0, 32'h0, 10'h0, 0, 10'h0, 1);
    stall = 1; salto_tomado = 1; dir_salto = 10'h5;
    repeat (2) tick();
    check("reset_ignores_ctrl", 0, 32'h0, 10'h0, 0, 10'h0, 1);
    @(negedge clk);
    rst_n = 1'b1; stall = 0; salto_tomado = 0;
    tick();
    check("post_reset_bubble", 0, 32'h0, 10'h0, 0, 10'h0, 1);
    tick();
    check("post_reset_first", 1, 32'h00210820, 10'h1, 0, 10'h1, 1);

    // Redirect while still in the start-up bubble
    do_reset();
    salto_tomado = 1; dir_salto = 10'h2;
    tick();
    check("arranque_salto", 0, 32'h0, 10'h0, 0, 10'h2, 0);
    salto_tomado = 0;
    tick();
    check("arranque_burbuja", 0, 32'h0, 10'h0, 0, 10'h2, 0);
    tick();
    check("arranque_destino", 1, 32'h00212020, 10'h3, 0, 10'h3, 1);

    // Randomized run against the reference model
    for (int i = 0; i < 1024; i++)
      rom[i] = ($urandom_range(0, 31) == 0) ? 32'h0 : ($urandom | 32'h1);
    do_reset();
    modelo_reset();
    for (int c = 0; c < 10000; c++) begin
      bit st, sl;
      int dst;
      st  = ($urandom_range(0, 3) == 0);
      sl  = ($urandom_range(0, 9) == 0);
      dst = $urandom_range(0, 1023);
      stall = st; salto_tomado = sl; dir_salto = dst[9:0];
      tick();
      modelo_paso(st, sl, dst);
      check("random_model", m_v, m_ins, m_p1[9:0], m_alto, m_pc[9:0], m_v);
      if (ifid_valido === 1'b1) begin
        n_vec++;
        if (ifid_instruccion !== rom[ifid_pc_mas1 - 10'd1]) begin
          n_err++;
          $display("FAIL random_rom_match: got ins=%h at p1=%h, expected %h",
                   ifid_instruccion, ifid_pc_mas1, rom[ifid_pc_mas1 - 10'd1]);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
